// File: rtl/fft_regfile_sequencer.sv
// fft_regfile_sequencer: control FSM that walks the FFT register file through
// one transform (clear, input load, five MAC passes, output hand-off) and
// drives every register enable, the local clear and the MAC input mux select.
module fft_regfile_sequencer #(
  parameter int MAC_LAT = 2,  // MAC input-to-output latency, 1..15
  parameter int CNT_W   = 4   // latency counter width, holds MAC_LAT-1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       Local_reset,
  output logic       Wr_En_x,
  output logic       Wr_En_A,
  output logic       Wr_En_B,
  output logic       Wr_En_C,
  output logic       Wr_En_D,
  output logic       Wr_En_X,
  output logic       Rd_En_x,
  output logic       Rd_En_A,
  output logic       Rd_En_B,
  output logic       Rd_En_C,
  output logic       Rd_En_D,
  output logic       Rd_En_X,
  output logic [2:0] MAC_IN_Sel,
  output logic       out_valid,
  output logic       busy,
  output logic       done,
  output logic [2:0] pass
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_RUN,
    S_WRITE,
    S_OUT,
    S_DONE
  } state_t;

  // Registered output bundle; rd bit 0..5 = x,A,B,C,D,X and wr_dst bit
  // 0..4 = A,B,C,D,X (pass p reads rd[p] and writes wr_dst[p]).
  typedef struct packed {
    logic       local_reset;
    logic [4:0] wr_dst;
    logic [5:0] rd;
    logic [2:0] sel;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic [2:0] pass;
  } outs_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAC_LAT - 1);
  localparam logic [2:0]       LAST_PASS = 3'd4;

  state_t           state_q, state_d;
  logic [2:0]       pass_q, pass_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  outs_t            outs_q, outs_d;

  // State, pass/counter and output registers; reset returns to IDLE at once.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking = here would let later lines see this edge's updates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pass_q  <= '0;
      cnt_q   <= '0;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      outs_q  <= outs_d;
    end
  end

  // Next-state logic; abort outside IDLE overrides every other transition.
  // NOTE: each variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE:  if (start && !abort) state_d = S_CLR;
      S_CLR:   state_d = S_LOAD;
      S_LOAD: begin
        if (in_valid) begin
          state_d = S_RUN;
          pass_d  = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) state_d = S_WRITE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_WRITE: begin
        if (pass_q == LAST_PASS) begin
          state_d = S_OUT;
        end else begin
          state_d = S_RUN;
          pass_d  = pass_q + 3'd1;
          cnt_d   = '0;
        end
      end
      S_OUT:   if (out_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      pass_d  = '0;
      cnt_d   = '0;
    end
  end

  // Output decode from the next state, registered so outputs are glitch-free
  // Moore values that line up with the state they describe.
  always_comb begin
    outs_d = '0;
    unique case (state_d)
      S_CLR: begin
        outs_d.local_reset = 1'b1;
        outs_d.busy        = 1'b1;
      end
      S_LOAD: outs_d.busy = 1'b1;
      S_RUN, S_WRITE: begin
        outs_d.busy       = 1'b1;
        outs_d.sel        = pass_d;
        outs_d.pass       = pass_d;
        outs_d.rd[pass_d] = 1'b1;
        if (state_d == S_WRITE) outs_d.wr_dst[pass_d] = 1'b1;
      end
      S_OUT: begin
        outs_d.busy      = 1'b1;
        outs_d.out_valid = 1'b1;
        outs_d.rd[5]     = 1'b1;
      end
      S_DONE: begin
        outs_d.busy = 1'b1;
        outs_d.done = 1'b1;
      end
      default: ;
    endcase
  end

  // The input load strobe must land in the very cycle in_valid is seen, so it
  // is qualified by in_valid directly; abort suppresses a half-committed load.
  assign Wr_En_x     = (state_q == S_LOAD) && in_valid && !abort;

  assign Local_reset = outs_q.local_reset;
  assign Wr_En_A     = outs_q.wr_dst[0];
  assign Wr_En_B     = outs_q.wr_dst[1];
  assign Wr_En_C     = outs_q.wr_dst[2];
  assign Wr_En_D     = outs_q.wr_dst[3];
  assign Wr_En_X     = outs_q.wr_dst[4];
  assign Rd_En_x     = outs_q.rd[0];
  assign Rd_En_A     = outs_q.rd[1];
  assign Rd_En_B     = outs_q.rd[2];
  assign Rd_En_C     = outs_q.rd[3];
  assign Rd_En_D     = outs_q.rd[4];
  assign Rd_En_X     = outs_q.rd[5];
  assign MAC_IN_Sel  = outs_q.sel;
  assign out_valid   = outs_q.out_valid;
  assign busy        = outs_q.busy;
  assign done        = outs_q.done;
  assign pass        = outs_q.pass;

endmodule
